// File: rtl/chunk_serial_adder.sv
// Multi-cycle adder/subtractor: processes a WIDTH-bit operand pair CHUNK bits
// per clock, LSB chunk first, with a registered carry chaining the chunks.
module chunk_serial_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             carry;
    logic [KW-1:0]    k;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] slice_sum;
    logic             slice_carry;
    logic             carry_into_msb;

    // One CHUNK-bit ripple slice, addressed by the chunk index.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        acc_next = acc;
        a_chunk  = op_a[k*CHUNK +: CHUNK];
        b_chunk  = op_b[k*CHUNK +: CHUNK];
        {slice_carry, slice_sum} = {1'b0, a_chunk} + {1'b0, b_chunk}
                                 + {{CHUNK{1'b0}}, carry};
        acc_next[k*CHUNK +: CHUNK] = slice_sum;
        // Sum bit = a ^ b ^ cin, so the carry into the slice MSB falls out of it.
        carry_into_msb = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ slice_sum[CHUNK-1];
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            acc      <= '0;
            carry    <= 1'b0;
            k        <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtract as a + ~b + 1, so c_out=1 means no borrow.
                        op_a  <= a;
                        op_b  <= mode ? ~b : b;
                        carry <= mode ? 1'b1 : c_in;
                        acc   <= '0;
                        k     <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    carry <= slice_carry;
                    if (k == LAST_K) begin
                        k        <= '0;
                        sum      <= acc_next;
                        c_out    <= slice_carry;
                        overflow <= carry_into_msb ^ slice_carry;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chunk_serial_adder.sv
// Scoreboard bench for chunk_serial_adder: three instances cover N=2, N=16
// and N=1; only one instance is active at a time so one queue serves all.
module tb_chunk_serial_adder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        mode;
    logic        c_in;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  start_v;
    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic [2:0]  c_v;
    logic [2:0]  v_v;
    logic [7:0]  s0;
    logic [15:0] s1;
    logic [7:0]  s2;
    logic [15:0] sum_x [3];

    assign sum_x[0] = {8'h00, s0};
    assign sum_x[1] = s1;
    assign sum_x[2] = {8'h00, s2};

    chunk_serial_adder #(.WIDTH(8), .CHUNK(4)) dut_w8c4 (
        .clk(clk), .reset(reset), .start(start_v[0]), .mode(mode),
        .a(a[7:0]), .b(b[7:0]), .c_in(c_in),
        .busy(busy_v[0]), .done(done_v[0]), .sum(s0), .c_out(c_v[0]), .overflow(v_v[0])
    );

    chunk_serial_adder #(.WIDTH(16), .CHUNK(1)) dut_w16c1 (
        .clk(clk), .reset(reset), .start(start_v[1]), .mode(mode),
        .a(a), .b(b), .c_in(c_in),
        .busy(busy_v[1]), .done(done_v[1]), .sum(s1), .c_out(c_v[1]), .overflow(v_v[1])
    );

    chunk_serial_adder #(.WIDTH(8), .CHUNK(8)) dut_w8c8 (
        .clk(clk), .reset(reset), .start(start_v[2]), .mode(mode),
        .a(a[7:0]), .b(b[7:0]), .c_in(c_in),
        .busy(busy_v[2]), .done(done_v[2]), .sum(s2), .c_out(c_v[2]), .overflow(v_v[2])
    );

    typedef struct {
        int          id;
        logic [15:0] sum;
        logic        c;
        logic        v;
        int          done_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [15:0] hold_s [3];
    logic        hold_c [3];
    logic        hold_v [3];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse, otherwise checks that
    // the result registers hold their last completed value.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                hold_s[i] = '0;
                hold_c[i] = 1'b0;
                hold_v[i] = 1'b0;
            end else if (done_v[i]) begin
                if (sb.size() == 0) begin
                    check("done_without_op", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    check("done_dut_id",  32'(i),         32'(e.id));
                    check("done_cycle",   32'(cyc),       32'(e.done_cyc));
                    check("sum",          32'(sum_x[i]),  32'(e.sum));
                    check("c_out",        32'(c_v[i]),    32'(e.c));
                    check("overflow",     32'(v_v[i]),    32'(e.v));
                    check("busy_at_done", 32'(busy_v[i]), 32'd0);
                    hold_s[i] = e.sum;
                    hold_c[i] = e.c;
                    hold_v[i] = e.v;
                end
            end else begin
                check("hold_sum",      32'(sum_x[i]), 32'(hold_s[i]));
                check("hold_c_out",    32'(c_v[i]),   32'(hold_c[i]));
                check("hold_overflow", 32'(v_v[i]),   32'(hold_v[i]));
            end
        end
    end

    task automatic push(input int id, input logic [15:0] s, input logic c, input logic v, input int n);
        exp_t x;
        x.id       = id;
        x.sum      = s;
        x.c        = c;
        x.v        = v;
        x.done_cyc = cyc + n;
        sb.push_back(x);
    endtask

    task automatic drain();
        for (int t = 0; t < 60 && sb.size() != 0; t++) @(negedge clk);
        check("drain_timeout_left", 32'(sb.size()), 32'd0);
    endtask

    task automatic run_op(input int id, input logic m, input logic [15:0] aa, input logic [15:0] bb,
                          input logic ci, input logic [15:0] es, input logic ec, input logic ev,
                          input int n);
        @(posedge clk); #1;
        mode = m; a = aa; b = bb; c_in = ci; start_v[id] = 1'b1;
        @(posedge clk); #1;
        start_v[id] = 1'b0;
        push(id, es, ec, ev, n);
        @(negedge clk);
        check("busy_after_start", 32'(busy_v[id]), 32'd1);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; start_v = '0; mode = 1'b0; c_in = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("reset_busy", 32'(busy_v[i]), 32'd0);
            check("reset_done", 32'(done_v[i]), 32'd0);
        end

        // WIDTH=8, CHUNK=4 (N=2)
        run_op(0, 1'b0, 16'h003C, 16'h0045, 1'b0, 16'h0081, 1'b0, 1'b1, 2);
        run_op(0, 1'b0, 16'h00FF, 16'h0001, 1'b1, 16'h0001, 1'b1, 1'b0, 2);
        run_op(0, 1'b1, 16'h0010, 16'h0020, 1'b1, 16'h00F0, 1'b0, 1'b0, 2);
        run_op(0, 1'b1, 16'h0080, 16'h0001, 1'b0, 16'h007F, 1'b1, 1'b1, 2);

        // Start pulsed while busy, with new operands: must be ignored.
        @(posedge clk); #1;
        mode = 1'b0; a = 16'h0012; b = 16'h0034; c_in = 1'b0; start_v[0] = 1'b1;
        @(posedge clk); #1;
        push(0, 16'h0046, 1'b0, 1'b0, 2);
        mode = 1'b1; a = 16'h00FF; b = 16'h00FF; c_in = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        drain();

        // Start held high: one result every N+1 = 3 cycles.
        @(posedge clk); #1;
        mode = 1'b0; a = 16'h0070; b = 16'h0010; c_in = 1'b0; start_v[0] = 1'b1;
        @(posedge clk); #1;
        push(0, 16'h0080, 1'b0, 1'b1, 2);
        for (int r = 0; r < 2; r++) begin
            repeat (3) @(posedge clk);
            #1 push(0, 16'h0080, 1'b0, 1'b1, 2);
        end
        start_v[0] = 1'b0;
        drain();

        // Reset one cycle after start: abort, no done, outputs cleared.
        @(posedge clk); #1;
        mode = 1'b0; a = 16'h0001; b = 16'h0001; c_in = 1'b0; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy",     32'(busy_v[0]), 32'd0);
        check("abort_done",     32'(done_v[0]), 32'd0);
        check("abort_sum",      32'(s0),        32'd0);
        check("abort_overflow", 32'(v_v[0]),    32'd0);
        repeat (4) @(negedge clk);

        // Reset and start in the same cycle: reset wins.
        @(posedge clk); #1;
        mode = 1'b0; a = 16'h0005; b = 16'h0005; reset = 1'b1; start_v[0] = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; start_v[0] = 1'b0;
        @(negedge clk);
        check("reset_start_busy", 32'(busy_v[0]), 32'd0);
        repeat (4) @(negedge clk);

        // WIDTH=16, CHUNK=1 (N=16)
        run_op(1, 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 16);
        run_op(1, 1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 16);

        // WIDTH=8, CHUNK=8 (N=1)
        run_op(2, 1'b0, 16'h00C8, 16'h0064, 1'b0, 16'h002C, 1'b1, 1'b0, 1);
        run_op(2, 1'b1, 16'h0005, 16'h0007, 1'b0, 16'h00FE, 1'b0, 1'b0, 1);
        run_op(2, 1'b0, 16'h007F, 16'h0000, 1'b1, 16'h0080, 1'b0, 1'b1, 1);

        repeat (3) @(negedge clk);
        check("scoreboard_left", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
